// File: rtl/proc_pkg.sv
// Shared processor constants: datapath word width and the default
// branch-offset shift used by branch-target logic, plus a small helper
// for sizing the carry-split chunks of pipelined adders.
package proc_pkg;

    localparam int WORD_W       = 16;
    localparam int BRANCH_SHIFT = 1;

    // Width of one carry-split chunk when a WIDTH-bit add is cut into STAGES pieces.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One stage of the carry-split pipelined adder. Stage IDX adds chunk IDX of
// the two operands together with the carry registered by the previous stage.
// The chunk result is merged into the partial sum, and both operands travel
// alongside to the next stage. Every register loads only when the global
// advance is high, so a stall freezes the whole pipe.
// Optional feature macro: PIPE_ADDER_OVF_EN adds a signed-overflow flag
// taken from the MSB of this stage's chunk (used only for the last stage).
module pipe_adder_stage
    import proc_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] off_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] base_o,
    output logic [WIDTH-1:0] off_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CHUNK_W = chunk_width(WIDTH, STAGES);
    localparam int LO      = IDX * CHUNK_W;
    localparam int HI      = LO + CHUNK_W - 1;

    logic [CHUNK_W:0] chunk_res;

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] base_d, base_q;
    logic [WIDTH-1:0] off_d, off_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_d, ovf_q;
`endif

    // Add this stage's chunk plus incoming carry and splice it into the partial sum.
    always_comb begin
        chunk_res = {1'b0, base_i[HI:LO]} + {1'b0, off_i[HI:LO]}
                  + {{CHUNK_W{1'b0}}, carry_i};
        sum_d          = sum_i;
        sum_d[HI:LO]   = chunk_res[CHUNK_W-1:0];
        carry_d        = chunk_res[CHUNK_W];
        valid_d        = valid_i;
        base_d         = base_i;
        off_d          = off_i;
`ifdef PIPE_ADDER_OVF_EN
        // carry into the chunk MSB is recovered from the MSB sum bit; XOR with carry out
        ovf_d = (base_i[HI] ^ off_i[HI] ^ chunk_res[CHUNK_W-1]) ^ chunk_res[CHUNK_W];
`endif
    end

    // Stage registers: cleared by reset, otherwise load only while the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            base_q  <= '0;
            off_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (advance) begin
            valid_q <= valid_d;
            base_q  <= base_d;
            off_q   <= off_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign base_o  = base_q;
    assign off_o   = off_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined base + (sign-extended offset << SHIFT) adder, e.g. for branch
// targets. The add is split into STAGES equal chunks, LSB chunk first, one
// chunk per pipeline stage, with a single global advance/stall signal and
// valid/ready handshakes on both sides. MSB carry-out wraps silently.
// Optional feature macro: PIPE_ADDER_OVF_EN adds the out_ovf port carrying
// the signed-overflow flag aligned with out_sum.
module pipe_adder
    import proc_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int OFF_W  = 8,
    parameter int SHIFT  = BRANCH_SHIFT,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [OFF_W-1:0] in_off,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    logic             advance;
    logic [WIDTH-1:0] off_sext;
    logic [WIDTH-1:0] off_shifted;

    // Element k feeds stage k; element STAGES is the output of the last stage.
    logic             valid_p [0:STAGES];
    logic [WIDTH-1:0] base_p  [0:STAGES];
    logic [WIDTH-1:0] off_p   [0:STAGES];
    logic [WIDTH-1:0] sum_p   [0:STAGES];
    logic             carry_p [0:STAGES];
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_p   [1:STAGES];
`endif

    // The pipe moves whenever the output slot is empty or being drained.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign off_sext    = WIDTH'($signed(in_off));
    assign off_shifted = off_sext << SHIFT;

    assign valid_p[0] = in_valid;
    assign base_p[0]  = in_base;
    assign off_p[0]   = off_shifted;
    assign sum_p[0]   = '0;
    assign carry_p[0] = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .valid_i (valid_p[k]),
            .base_i  (base_p[k]),
            .off_i   (off_p[k]),
            .sum_i   (sum_p[k]),
            .carry_i (carry_p[k]),
            .valid_o (valid_p[k+1]),
            .base_o  (base_p[k+1]),
            .off_o   (off_p[k+1]),
            .sum_o   (sum_p[k+1]),
            .carry_o (carry_p[k+1])
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf_o   (ovf_p[k+1])
`endif
        );
    end

    assign out_valid = valid_p[STAGES];
    assign out_sum   = sum_p[STAGES];
`ifdef PIPE_ADDER_OVF_EN
    assign out_ovf   = ovf_p[STAGES];
`endif

endmodule
